kronos_alu_mc: RTL and testbench



---
 rtl/kronos_alu_mc_pkg.sv | 17 +
 rtl/kronos_alu_mc_shstep.sv | 21 ++
 rtl/kronos_alu_mc.sv | 154 +++++++++++++++
 tb/tb_kronos_alu_mc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_alu_mc_pkg.sv
// Shared aluop encodings and FSM state type for the multi-cycle Kronos ALU.
package kronos_types;

   localparam logic [3:0] ADD  = 4'b0000;
   localparam logic [3:0] SUB  = 4'b1000;
   localparam logic [3:0] SLL  = 4'b0001;
   localparam logic [3:0] SLT  = 4'b0010;
   localparam logic [3:0] SLTU = 4'b0011;
   localparam logic [3:0] XOR  = 4'b0100;
   localparam logic [3:0] SRL  = 4'b0101;
   localparam logic [3:0] SRA  = 4'b1101;
   localparam logic [3:0] OR   = 4'b0110;
   localparam logic [3:0] AND  = 4'b0111;

   typedef enum logic {IDLE, SHIFT} alu_mc_state_e;

endpackage

// File: rtl/kronos_alu_mc_shstep.sv
// One iteration of the multi-cycle shifter: shifts XLEN bits by 0..SHIFT_STEP.
module kronos_alu_shstep #(
   parameter int XLEN = 32,
   parameter int AW   = 3
) (
   input  logic [XLEN-1:0] i_data,
   input  logic [AW-1:0]   i_amt,
   input  logic            i_left,
   input  logic            i_arith,
   output logic [XLEN-1:0] o_data
);

   logic signed [XLEN:0] w_ext;

   always_comb begin
      w_ext = {i_arith & i_data[XLEN-1], i_data};
      if (i_left) o_data = i_data << i_amt;
      else        o_data = XLEN'(w_ext >>> i_amt);
   end

endmodule

// File: rtl/kronos_alu_mc.sv
// Multi-cycle RV32I/RV64I integer ALU with valid/ready handshake and registered result.
// Define KRONOS_ALU_FAST_SHIFT_EN for a single-cycle barrel shifter instead of the iterative one.
module kronos_alu_mc
   import kronos_types::*;
#(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_vld,
   output logic            in_rdy,
   input  logic [3:0]      aluop,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            out_vld,
   input  logic            out_rdy,
   output logic [XLEN-1:0] result
);

   localparam int SW = $clog2(XLEN);

   alu_mc_state_e   r_state;
   logic            r_out_vld;
   logic [XLEN-1:0] r_result;

   logic [3:0]      w_op;
   logic            w_cin, w_uns, w_lt, w_left, w_is_shift, w_iter, w_accept;
   logic [XLEN:0]   w_sum;
   logic [SW-1:0]   w_shamt;
   logic [XLEN-1:0] w_shres, w_res;

   // Unlisted encodings collapse to ADD so they never pick up the subtract carry-in.
   always_comb begin
      case (aluop)
         ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND: w_op = aluop;
         default:                                          w_op = ADD;
      endcase
   end

   assign w_cin      = w_op[3] | w_op[1];
   assign w_uns      = w_op[0];
   assign w_sum      = {1'b0, op1} + {1'b0, op2 ^ {XLEN{w_cin}}} + {{XLEN{1'b0}}, w_cin};
   assign w_lt       = w_uns ? ~w_sum[XLEN]
                     : (op1[XLEN-1] == op2[XLEN-1]) ? w_sum[XLEN-1] : op1[XLEN-1];
   assign w_shamt    = op2[SW-1:0];
   assign w_is_shift = (w_op[1:0] == 2'b01);
   assign w_left     = ~w_op[2];

`ifdef KRONOS_ALU_FAST_SHIFT_EN
   logic [XLEN-1:0]      w_rin, w_sh;
   logic signed [XLEN:0] w_rext;

   // Left shifts reuse the right shifter by reversing bits on the way in and out.
   always_comb begin
      for (int i = 0; i < XLEN; i++) w_rin[i] = w_left ? op1[XLEN-1-i] : op1[i];
      w_rext = {w_cin & w_rin[XLEN-1], w_rin};
      w_sh   = XLEN'(w_rext >>> w_shamt);
      for (int i = 0; i < XLEN; i++) w_shres[i] = w_left ? w_sh[XLEN-1-i] : w_sh[i];
   end

   assign w_iter = 1'b0;
`else
   localparam int          AW   = $clog2(SHIFT_STEP + 1);
   localparam logic [SW:0] STEP = SW'(SHIFT_STEP) == '0 ? (SW+1)'(SHIFT_STEP) : (SW+1)'(SHIFT_STEP);

   logic [XLEN-1:0] r_acc, w_shout;
   logic [SW-1:0]   r_rem;
   logic            r_left, r_arith, w_last;
   logic [AW-1:0]   w_step;

   assign w_last  = ({1'b0, r_rem} <= STEP);
   assign w_step  = w_last ? AW'(r_rem) : AW'(SHIFT_STEP);
   assign w_shres = op1;
   assign w_iter  = w_is_shift && (w_shamt != '0);

   kronos_alu_shstep #(.XLEN(XLEN), .AW(AW)) u_shstep (
      .i_data  (r_acc),
      .i_amt   (w_step),
      .i_left  (r_left),
      .i_arith (r_arith),
      .o_data  (w_shout)
   );
`endif

   always_comb begin
      case (w_op[2:0])
         3'b000:         w_res = w_sum[XLEN-1:0];
         3'b001, 3'b101: w_res = w_shres;
         3'b010, 3'b011: w_res = {{(XLEN-1){1'b0}}, w_lt};
         3'b100:         w_res = op1 ^ op2;
         3'b110:         w_res = op1 | op2;
         default:        w_res = op1 & op2;
      endcase
   end

   assign in_rdy   = !rst && (r_state == IDLE) && (!r_out_vld || out_rdy) && !flush;
   assign w_accept = in_vld && in_rdy;
   assign out_vld  = r_out_vld;
   assign result   = r_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_out_vld <= 1'b0;
         r_result  <= '0;
`ifndef KRONOS_ALU_FAST_SHIFT_EN
         r_acc     <= '0;
         r_rem     <= '0;
         r_left    <= 1'b0;
         r_arith   <= 1'b0;
`endif
      end else if (flush) begin
         r_state   <= IDLE;
         r_out_vld <= 1'b0;
      end else begin
         if (r_out_vld && out_rdy) r_out_vld <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_iter) begin
`ifndef KRONOS_ALU_FAST_SHIFT_EN
                     r_acc   <= op1;
                     r_rem   <= w_shamt;
                     r_left  <= w_left;
                     r_arith <= w_cin;
`endif
                     r_state <= SHIFT;
                  end else begin
                     r_result  <= w_res;
                     r_out_vld <= 1'b1;
                  end
               end
            end
            SHIFT: begin
`ifndef KRONOS_ALU_FAST_SHIFT_EN
               r_acc <= w_shout;
               r_rem <= r_rem - SW'(w_step);
               if (w_last) begin
                  r_result  <= w_shout;
                  r_out_vld <= 1'b1;
                  r_state   <= IDLE;
               end
`else
               r_state <= IDLE;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kronos_alu_mc.sv
// Directed bench for kronos_alu_mc with a cycle-level reference model and literal checks.
module tb_kronos_alu_mc;
   import kronos_types::*;

   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_vld = 1'b0, out_rdy = 1'b1;
   logic [3:0]  aluop = 4'd0;
   logic [31:0] op1 = '0, op2 = '0;
   logic        in_rdy, out_vld;
   logic [31:0] result;

   logic        a_flush = 1'b0, a_in_vld = 1'b0, a_out_rdy = 1'b1;
   logic [3:0]  a_aluop = 4'd0;
   logic [63:0] a_op1 = '0, a_op2 = '0;
   logic        a_in_rdy, a_out_vld;
   logic [63:0] a_result;

   int n_cmp = 0, n_err = 0;

   kronos_alu_mc #(.XLEN(32), .SHIFT_STEP(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
      .aluop(aluop), .op1(op1), .op2(op2), .out_vld(out_vld), .out_rdy(out_rdy), .result(result)
   );

   kronos_alu_mc #(.XLEN(64), .SHIFT_STEP(4)) dut64 (
      .clk(clk), .rst(rst), .flush(a_flush), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
      .aluop(a_aluop), .op1(a_op1), .op2(a_op2), .out_vld(a_out_vld), .out_rdy(a_out_rdy),
      .result(a_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference semantics straight from the ISA definitions.
   function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0001: return a << sh;
         4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0011: return (a < b) ? 32'd1 : 32'd0;
         4'b0100: return a ^ b;
         4'b0101: return a >> sh;
         4'b1101: return $signed(a) >>> sh;
         4'b0110: return a | b;
         4'b0111: return a & b;
         default: return a + b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      if ((op == 4'b0001 || op == 4'b0101 || op == 4'b1101) && sh > 0) return 1 + (sh + 3) / 4;
      return 1;
   endfunction

   logic        m_vld = 1'b0;
   logic [31:0] m_res = '0, m_pend = '0;
   int          m_busy = 0;

   // Check DUT against the model, then advance the model by one clock.
   always @(negedge clk) begin
      logic exp_rdy;
      int   lat;
      exp_rdy = !rst && (m_busy == 0) && (!m_vld || out_rdy) && !flush;
      chk("model_in_rdy", in_rdy, exp_rdy);
      chk("model_out_vld", out_vld, m_vld);
      chk("model_result", result, m_res);
      if (rst) begin
         m_vld = 1'b0; m_res = '0; m_busy = 0;
      end else if (flush) begin
         m_vld = 1'b0; m_busy = 0;
      end else begin
         if (m_vld && out_rdy) m_vld = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin m_vld = 1'b1; m_res = m_pend; end
         end else if (in_vld && exp_rdy) begin
            lat = ref_lat(aluop, op2);
            if (lat == 1) begin m_vld = 1'b1; m_res = ref_res(aluop, op1, op2); end
            else begin m_busy = lat - 1; m_pend = ref_res(aluop, op1, op2); end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      in_vld = 1'b1; aluop = op; op1 = a; op2 = b;
      #1;
      while (!in_rdy && n < 50) begin tick; n++; end
      if (!in_rdy) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: in_rdy got 0 expected 1");
      end
      tick;
   endtask

   logic [3:0]  t_op [8] = '{XOR, OR, AND, SRL, SRA, 4'b1010, SLL, SUB};
   logic [31:0] t_a  [8] = '{32'hF0F0_1234, 32'h0F00_00F0, 32'hFFFF_0000, 32'h8000_0001,
                             32'hF000_0000, 32'd100, 32'h0000_0003, 32'd5};
   logic [31:0] t_b  [8] = '{32'h0FF0_FFFF, 32'h00F0_0F00, 32'h0FF0_F0F0, 32'hFFFF_FFE7,
                             32'd9, 32'd7, 32'd30, 32'd10};

   initial begin
      repeat (3) tick;
      rst = 1'b0;
      #1;
      chk("rst_result", result, 32'h0);
      chk("rst_out_vld", out_vld, 1'b0);
      chk("rdy_after_rst", in_rdy, 1'b1);

      // 64-bit instance: signed vs unsigned compare on the top bit
      a_in_vld = 1'b1; a_aluop = SLT; a_op1 = 64'h8000_0000_0000_0000; a_op2 = '0;
      tick;
      chk("slt64_vld", a_out_vld, 1'b1);
      chk("slt64", a_result, 64'd1);
      a_aluop = SLTU;
      tick;
      chk("sltu64", a_result, 64'd0);
      a_in_vld = 1'b0;

      send(ADD, 32'h7FFF_FFFF, 32'd1);
      in_vld = 1'b0;
      chk("add_vld_c1", out_vld, 1'b1);
      chk("add_ovf", result, 32'h8000_0000);

      send(SUB, 32'd0, 32'd1);
      chk("sub", result, 32'hFFFF_FFFF);
      send(SLT, 32'hFFFF_FFFF, 32'd1);
      chk("slt", result, 32'd1);
      send(SLTU, 32'hFFFF_FFFF, 32'd1);
      chk("sltu", result, 32'd0);
      in_vld = 1'b0;

      send(SRA, 32'h8000_0000, 32'd31);
      in_vld = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         chk("sra_busy_vld", out_vld, 1'b0);
         chk("sra_busy_rdy", in_rdy, 1'b0);
         tick;
      end
      chk("sra_vld_c9", out_vld, 1'b1);
      chk("sra", result, 32'hFFFF_FFFF);

      send(SLL, 32'd1, 32'd4);
      in_vld = 1'b0;
      chk("sll_c1_vld", out_vld, 1'b0);
      tick;
      chk("sll", result, 32'h10);

      send(SRL, 32'h1234_5678, 32'd0);
      chk("shamt0", result, 32'h1234_5678);
      send(SLL, 32'h89AB_CDEF, 32'h20);
      chk("shamt_upper_ignored", result, 32'h89AB_CDEF);
      in_vld = 1'b0;
      tick;

      out_rdy = 1'b0;
      send(ADD, 32'd5, 32'd6);
      in_vld = 1'b0;
      chk("stall_c1", result, 32'd11);
      repeat (3) begin
         tick;
         chk("stall_hold", result, 32'd11);
         chk("stall_rdy", in_rdy, 1'b0);
      end
      out_rdy = 1'b1;
      #1;
      chk("handoff_rdy", in_rdy, 1'b1);
      send(ADD, 32'd1, 32'd2);
      in_vld = 1'b0;
      chk("handoff", result, 32'd3);

      send(SRL, 32'hFFFF_FFFF, 32'd20);
      in_vld = 1'b0;
      tick; tick;
      flush = 1'b1;
      #1;
      chk("flush_rdy", in_rdy, 1'b0);
      tick;
      flush = 1'b0;
      #1;
      chk("flush_vld", out_vld, 1'b0);
      chk("flush_rdy_next", in_rdy, 1'b1);
      repeat (6) tick;

      out_rdy = 1'b0;
      send(XOR, 32'hAAAA_AAAA, 32'hFFFF_0000);
      in_vld = 1'b0;
      flush = 1'b1;
      tick;
      flush = 1'b0; out_rdy = 1'b1;
      #1;
      chk("flush_held_vld", out_vld, 1'b0);

      send(SRA, 32'h8000_0000, 32'd31);
      in_vld = 1'b0;
      tick; tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      chk("midshift_rst_result", result, 32'h0);
      chk("midshift_rst_vld", out_vld, 1'b0);
      chk("midshift_rst_rdy", in_rdy, 1'b1);

      for (int i = 0; i < 8; i++) send(t_op[i], t_a[i], t_b[i]);
      in_vld = 1'b0;
      repeat (12) tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
